// File: rtl/serv_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// serv_arb_pkg
// Shared definitions for the SERV instruction/data bus arbiter:
//   - arb_state_t : one-hot FSM state encoding (IDLE, GNT_I, GNT_D, ERR)
//   - M_IBUS/M_DBUS : master identifiers used for round-robin bookkeeping
//   - cnt_width() : watchdog counter width derived from the timeout value
// ----------------------------------------------------------------------------
package serv_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_GNT_I = 4'b0010,
    ST_GNT_D = 4'b0100,
    ST_ERR   = 4'b1000
  } arb_state_t;

  localparam logic M_IBUS = 1'b0;
  localparam logic M_DBUS = 1'b1;

  // Width able to hold 0..TIMEOUT; a zero timeout still needs a 1-bit counter
  // so the declaration stays legal even though the watchdog is disabled.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    if (timeout == 0) begin
      return 1;
    end
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/serv_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// serv_bus_arbiter_if
// Bundles every bus signal around the arbiter:
//   ibus  : i_ibus_adr, i_ibus_cyc            -> o_ibus_rdt, o_ibus_ack
//   dbus  : i_dbus_adr/dat/sel/we/cyc         -> o_dbus_rdt, o_dbus_ack
//   wb    : o_wb_adr/dat/sel/we/cyc           <- i_wb_rdt, i_wb_ack
//   error : o_err (pulse), o_err_adr (sticky)
// Signal names keep the i_/o_ prefixes as seen from the arbiter.
// Modports:
//   slave  : the arbiter's view (serves the core buses, drives the wb port)
//   master : the environment's view (core masters plus the memory slave)
// ----------------------------------------------------------------------------
interface serv_bus_arbiter_if;

  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;

  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;

  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  logic        o_err;
  logic [31:0] o_err_adr;

  modport slave (
    input  i_ibus_adr, i_ibus_cyc,
    output o_ibus_rdt, o_ibus_ack,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    output o_dbus_rdt, o_dbus_ack,
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    input  i_wb_rdt, i_wb_ack,
    output o_err, o_err_adr
  );

  modport master (
    output i_ibus_adr, i_ibus_cyc,
    input  o_ibus_rdt, o_ibus_ack,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    input  o_dbus_rdt, o_dbus_ack,
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    output i_wb_rdt, i_wb_ack,
    input  o_err, o_err_adr
  );

endinterface

// File: rtl/serv_bus_arbiter_timer.sv
// ----------------------------------------------------------------------------
// serv_arb_timer
// Watchdog counter for the bus arbiter. Counts granted cycles that have not
// yet been acknowledged and flags the last permitted cycle.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear (held while no grant is active)
//   run    : count this cycle (granted, master still requesting, no ack)
//   expire : this is the TIMEOUT-th unacknowledged cycle; never set when
//            TIMEOUT is 0
// ----------------------------------------------------------------------------
module serv_arb_timer
  import serv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

  // The FSM leaves the grant when this fires, so count never passes LAST.
  assign expire = (TIMEOUT != 0) && run && (count == LAST);

endmodule

// File: rtl/serv_bus_arbiter.sv
// ----------------------------------------------------------------------------
// serv_bus_arbiter
// Shares one Wishbone slave port between SERV's read-only instruction bus and
// its data bus. Grants are registered; when both masters request in the same
// IDLE cycle the one that did not win last time is granted. Every grant is
// followed by at least one IDLE cycle. A watchdog ends any grant that sees no
// slave ack within TIMEOUT cycles with a one-cycle ERR state that acks the
// stalled master with zero data and records its address.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : serv_bus_arbiter_if.slave (ibus, dbus, wb port, error report)
// Parameters:
//   TIMEOUT : cycles to wait for a slave ack while granted; 0 disables
// ----------------------------------------------------------------------------
module serv_bus_arbiter
  import serv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  serv_bus_arbiter_if.slave     bus
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  logic        last_grant;
  logic [31:0] err_adr;

  logic        gnt_i;
  logic        gnt_d;
  logic        in_err;
  logic        granted;
  logic        gnt_cyc;
  logic        wd_run;
  logic        wd_expire;

  logic        wb_cyc;
  logic [31:0] wb_adr;
  logic        ibus_ack;
  logic        dbus_ack;
  logic        err;

  assign gnt_i   = (state == ST_GNT_I);
  assign gnt_d   = (state == ST_GNT_D);
  assign in_err  = (state == ST_ERR);
  assign granted = gnt_i | gnt_d;

  // Request line of whichever master currently owns the slave port.
  assign gnt_cyc = gnt_d ? bus.i_dbus_cyc : bus.i_ibus_cyc;

  // The watchdog only counts while the owner is still waiting on the slave;
  // an ack or an abort in the same cycle takes precedence over expiry.
  assign wd_run = granted & gnt_cyc & ~bus.i_wb_ack;

  serv_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (~granted),
    .run    (wd_run),
    .expire (wd_expire)
  );

  assign wb_adr = gnt_d ? bus.i_dbus_adr : bus.i_ibus_adr;

  // State register, round-robin history and error address capture.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      last_grant <= M_IBUS;
      err_adr    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_GNT_I) begin
        last_grant <= M_IBUS;
      end
      if (state == ST_IDLE && state_nxt == ST_GNT_D) begin
        last_grant <= M_DBUS;
      end
      // Captured on entry so the address is already valid during ERR.
      if (state_nxt == ST_ERR) begin
        err_adr <= wb_adr;
      end
    end
  end

  // Next state and control outputs.
  always_comb begin
    state_nxt = state;
    wb_cyc    = 1'b0;
    ibus_ack  = 1'b0;
    dbus_ack  = 1'b0;
    err       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.i_ibus_cyc && bus.i_dbus_cyc) begin
          state_nxt = (last_grant == M_IBUS) ? ST_GNT_D : ST_GNT_I;
        end else if (bus.i_dbus_cyc) begin
          state_nxt = ST_GNT_D;
        end else if (bus.i_ibus_cyc) begin
          state_nxt = ST_GNT_I;
        end
      end

      ST_GNT_I, ST_GNT_D: begin
        wb_cyc   = 1'b1;
        // Ack is only forwarded while the owner still requests, so an ack
        // that coincides with an abort is dropped.
        ibus_ack = gnt_i & bus.i_wb_ack & bus.i_ibus_cyc;
        dbus_ack = gnt_d & bus.i_wb_ack & bus.i_dbus_cyc;
        if (!gnt_cyc || bus.i_wb_ack) begin
          state_nxt = ST_IDLE;
        end else if (wd_expire) begin
          state_nxt = ST_ERR;
        end
      end

      ST_ERR: begin
        // last_grant still names the master whose access timed out.
        ibus_ack  = (last_grant == M_IBUS);
        dbus_ack  = (last_grant == M_DBUS);
        err       = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Slave port: dat/sel come straight from dbus and are only meaningful
  // while o_wb_cyc is high.
  assign bus.o_wb_cyc  = wb_cyc;
  assign bus.o_wb_adr  = wb_adr;
  assign bus.o_wb_dat  = bus.i_dbus_dat;
  assign bus.o_wb_sel  = bus.i_dbus_sel;
  assign bus.o_wb_we   = gnt_d & bus.i_dbus_we;

  assign bus.o_ibus_ack = ibus_ack;
  assign bus.o_dbus_ack = dbus_ack;
  assign bus.o_ibus_rdt = in_err ? 32'h0 : bus.i_wb_rdt;
  assign bus.o_dbus_rdt = in_err ? 32'h0 : bus.i_wb_rdt;

  assign bus.o_err     = err;
  assign bus.o_err_adr = err_adr;

endmodule

// File: doc/serv_bus_arbiter.md
Name: serv_bus_arbiter

Overview:
Shares one Wishbone slave port between the core's instruction bus (read-only) and data bus. Sits between the core top level and the single memory/peripheral port of a small SoC.
Grants are registered and alternate round-robin when both buses request at once. A watchdog terminates any slave access that gets no ack within TIMEOUT cycles and reports it as an error.

Parameters:
TIMEOUT, 255, cycles to wait for slave ack while granted; 0 disables the watchdog.
CNT_W, $clog2(TIMEOUT+1) (minimum 1), width of the watchdog counter; derived, do not override.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_ibus_adr  in  32  instruction fetch address
i_ibus_cyc  in  1  instruction request; held high until o_ibus_ack
o_ibus_rdt  out  32  instruction read data
o_ibus_ack  out  1  one-cycle completion strobe to ibus
i_dbus_adr  in  32  data address
i_dbus_dat  in  32  write data
i_dbus_sel  in  4  byte lanes
i_dbus_we  in  1  1 = write
i_dbus_cyc  in  1  data request; held high until o_dbus_ack
o_dbus_rdt  out  32  load data
o_dbus_ack  out  1  one-cycle completion strobe to dbus
o_wb_adr  out  32  slave address
o_wb_dat  out  32  slave write data
o_wb_sel  out  4  slave byte lanes
o_wb_we  out  1  slave write enable
o_wb_cyc  out  1  slave cycle/strobe
i_wb_rdt  in  32  slave read data
i_wb_ack  in  1  slave ack
o_err  out  1  one-cycle pulse on watchdog expiry
o_err_adr  out  32  address of the last timed-out access (sticky)

Behaviour:
- Clock and reset: single clock i_clk; reset is asynchronous, active-low (i_rst_n).
- Reset values: state IDLE, last_grant = IBUS, watchdog counter 0, o_err_adr 0.
- Reset consequences: o_wb_cyc, both acks, o_err and o_wb_we are 0 immediately on reset assertion, not waiting for a clock edge.
- States: IDLE, GNT_I, GNT_D, ERR. Encoding is one-hot.
- IDLE, one requester: with only i_ibus_cyc high, next state is GNT_I. With only i_dbus_cyc high, next state is GNT_D.
- IDLE, both requesting: grant the master that is not last_grant. After reset, dbus wins.
- Grant timing: last_grant updates on entry to GNT_I/GNT_D. Request in cycle N gives o_wb_cyc high in cycle N+1.
- Slave outputs while granted:
  - o_wb_cyc = GNT_I | GNT_D.
  - o_wb_adr = i_dbus_adr in GNT_D, otherwise i_ibus_adr.
  - o_wb_dat = i_dbus_dat; o_wb_sel = i_dbus_sel.
  - o_wb_we = GNT_D & i_dbus_we.
  - These are combinational from registered state; slave outputs are qualified only by o_wb_cyc.
- Completion: o_ibus_ack = GNT_I & i_wb_ack & i_ibus_cyc. o_dbus_ack is the same with GNT_D and i_dbus_cyc.
- After completion: on the ack cycle the next state is IDLE. A minimum one-cycle IDLE gap follows every grant; back-to-back throughput is 1 access per 2 + slave-latency cycles.
- Read data: o_ibus_rdt = o_dbus_rdt = i_wb_rdt, except in ERR where both are 0.
- Abort: if the granted master drops cyc before the ack, go to IDLE next cycle and clear the counter. An ack in that same cycle is not forwarded.
- Stray ack: i_wb_ack in IDLE or ERR is ignored.
- Watchdog: counter clears on entry to a grant state. It increments each granted cycle without ack.
- Watchdog expiry: when the counter equals TIMEOUT-1 and there is no ack, the next state is ERR.
- ERR state (exactly one cycle):
  - o_wb_cyc = 0.
  - The ack of the master granted previously is asserted, with its rdt = 0.
  - o_err = 1, and o_err_adr captures that master's address.
  - Next state is IDLE.
- Watchdog priority: ack and expiry in the same cycle resolve as ack; ERR is not entered. TIMEOUT = 0 means ERR is unreachable.
- Master contract: each master holds adr/dat/sel/we stable while its cyc is high. The arbiter does not register them.

Decomposition:
- Package serv_arb_pkg: state one-hot constants (ST_IDLE, ST_GNT_I, ST_GNT_D, ST_ERR) and master id constants (M_IBUS = 0, M_DBUS = 1).
- One sub-module, serv_arb_timer: watchdog counter.
  - Inputs: clk, rst_n, clr, run.
  - Output: expire, asserted when count == TIMEOUT-1 && run && TIMEOUT != 0.
- The FSM, muxes and error capture stay in serv_bus_arbiter.

Test Plan:
- Reset mid-grant: assert i_rst_n = 0 while in GNT_D -> o_wb_cyc drops before the next clock edge. After release, state is IDLE and o_err_adr = 0.
- Single ibus fetch: i_ibus_cyc = 1 adr = 0x100 at cycle 0, slave ack at cycle 3 with rdt = 0x00000013 -> o_wb_cyc 1 in cycles 1-3, o_wb_adr = 0x100, o_wb_we = 0. o_ibus_ack = 1 in cycle 3 only, o_ibus_rdt = 0x13, o_wb_cyc = 0 in cycle 4.
- Simultaneous requests after reset: both cyc high, slave acks each grant after 1 cycle -> dbus granted first, then IDLE, then ibus. With both held requesting, grants alternate D, I, D, I.
- Dbus write: adr = 0x2004 dat = 0xDEADBEEF sel = 0xC we = 1 -> slave sees identical values with o_wb_we = 1. o_ibus_ack stays 0 throughout.
- Timeout, TIMEOUT = 4: dbus read to 0x3000, slave never acks -> o_wb_cyc high for 4 cycles. Then one ERR cycle with o_dbus_ack = 1, o_dbus_rdt = 0, o_err = 1, o_err_adr = 0x3000.
- Ack on the last watchdog cycle: same setup but ack on the 4th granted cycle -> normal ack, o_err stays 0.
- Abort: ibus drops cyc in cycle 2 while slave acks in cycle 2 -> o_ibus_ack stays 0 and state is IDLE in cycle 3.
